// File: rtl/seg7_scan_driver.sv
// Scanned N-digit common-anode 7-segment driver with one shared hex decoder,
// per-digit decimal points, optional leading-zero blanking and a frame-aligned double buffer.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter bit LZ_BLANK    = 1'b0,
  parameter int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt;
  logic [4*NUM_DIGITS-1:0] shadow_val, disp_val, val_nxt;
  logic [NUM_DIGITS-1:0]   shadow_dp, disp_dp, dp_nxt_vec;
  logic                    pending;

  logic                    tick, wrap;
  logic [IDX_W-1:0]        idx_nxt;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    all_zero;
  logic [3:0]              nib;
  logic [6:0]              seg_nxt;
  logic [NUM_DIGITS-1:0]   an_nxt;
  logic                    dp_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'b0000001;
      4'h1: hex7 = 7'b1001111;
      4'h2: hex7 = 7'b0010010;
      4'h3: hex7 = 7'b0000110;
      4'h4: hex7 = 7'b1001100;
      4'h5: hex7 = 7'b0100100;
      4'h6: hex7 = 7'b0100000;
      4'h7: hex7 = 7'b0001111;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0000100;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b1100000;
      4'hC: hex7 = 7'b0110001;
      4'hD: hex7 = 7'b1000010;
      4'hE: hex7 = 7'b0110000;
      default: hex7 = 7'b0111000;
    endcase
  endfunction

  always_comb begin
    tick    = en && (cnt == CNT_MAX);
    wrap    = tick && (digit_idx == IDX_MAX);
    idx_nxt = digit_idx;
    if (tick) idx_nxt = wrap ? '0 : digit_idx + 1'b1;
    // Display takes the shadow only at frame start so a frame never mixes old and new data.
    val_nxt    = (wrap && pending) ? shadow_val : disp_val;
    dp_nxt_vec = (wrap && pending) ? shadow_dp  : disp_dp;
  end

  always_comb begin
    all_zero = 1'b1;
    blank    = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      all_zero = all_zero && (val_nxt[4*k +: 4] == 4'h0);
      blank[k] = LZ_BLANK && (k != 0) && all_zero;
    end
  end

  always_comb begin
    nib     = val_nxt[{idx_nxt, 2'b00} +: 4];
    seg_nxt = blank[idx_nxt] ? 7'b1111111 : hex7(nib);
    an_nxt  = ~(NUM_DIGITS'(1) << idx_nxt);
    dp_nxt  = ~dp_nxt_vec[idx_nxt];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      digit_idx  <= '0;
      frame_done <= 1'b0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      pending    <= 1'b0;
      disp_val   <= '0;
      disp_dp    <= '0;
      seg        <= 7'b1111111;
      dp         <= 1'b1;
      an         <= '1;
    end else begin
      if (en) cnt <= tick ? '0 : cnt + 1'b1;
      digit_idx  <= idx_nxt;
      frame_done <= wrap;
      disp_val   <= val_nxt;
      disp_dp    <= dp_nxt_vec;
      // A load on the wrap edge lands in shadow and stays pending for the next frame.
      if (load) begin
        shadow_val <= value;
        shadow_dp  <= dp_in;
        pending    <= 1'b1;
      end else if (wrap) begin
        pending    <= 1'b0;
      end
      if (en) begin
        seg <= seg_nxt;
        dp  <= dp_nxt;
        an  <= an_nxt;
      end else begin
        seg <= 7'b1111111;
        dp  <= 1'b1;
        an  <= '1;
      end
    end
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for a parametrised N-digit common-anode seven-segment display.
- Decodes all 16 hex values (0-F), with per-digit decimal points, optional leading-zero blanking and tear-free double-buffered updates.
- Sits between the datapath and the board display pins.
- Replaces per-digit combinational decoders with one shared decoder scanned across digits.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8).
- REFRESH_DIV, 100000, clock cycles each digit stays lit (>=2); 100 MHz clock gives 1 ms per digit.
- LZ_BLANK, 0, 1 = blank leading zero digits (digit 0 is never blanked).
- IDX_W, $clog2(NUM_DIGITS) (min 1), width of digit_idx.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  1 = scan/display; 0 = display dark.
- load  input  1  1-cycle strobe; captures value and dp_in into the shadow register.
- value  input  4*NUM_DIGITS  hex digits; nibble k is digit k, digit 0 is least significant.
- dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit.
- seg  output  7  segment cathodes, active-low, bit order {a,b,c,d,e,f,g} (seg[6]=a, seg[0]=g).
- dp  output  1  decimal point cathode, active-low.
- an  output  NUM_DIGITS  digit anodes, active-low, one-hot-low when lit.
- digit_idx  output  IDX_W  index of the digit currently driven.
- frame_done  output  1  1-cycle pulse when digit_idx wraps NUM_DIGITS-1 -> 0.

Behaviour:
- Reset (rst_n=0 at a clk edge): prescaler=0, digit_idx=0, shadow=0, display regs=0, seg=7'b1111111, dp=1, an=all 1, frame_done=0.
  - Reset applies mid-scan; no pending load survives it.
- Prescaler counts 0..REFRESH_DIV-1 while en=1. tick = (count==REFRESH_DIV-1 && en); count wraps to 0 on tick.
- On tick: digit_idx <= (digit_idx==NUM_DIGITS-1) ? 0 : digit_idx+1.
  - frame_done=1 in the cycle after a wrap tick (registered with the index update), else 0.
  - NUM_DIGITS=1: every tick is a wrap.
- Double buffer:
  - load=1 copies value/dp_in into the shadow register and sets the pending flag.
  - Shadow is copied into the display registers on the edge where digit_idx wraps to 0; pending is cleared then.
  - load on that same edge: the new data goes to shadow and pending stays set. The display gets the old shadow; the new data waits for the next frame.
  - Back-to-back loads: last one wins.
  - en=0 while pending: the copy happens at the first wrap after en returns.
- Outputs are registered. an, seg and dp change on the same edge as digit_idx (computed from the next index) and are held otherwise.
  - an[k]=0 only for k==digit_idx; all other bits 1.
- Decode, active-low {a..g}:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
- dp = ~display_dp[digit_idx].
- LZ_BLANK=1: digit k>0 is blanked if display nibbles k..NUM_DIGITS-1 are all 0.
  - Blanked means seg=1111111 and an stays asserted for timing; dp is still driven from dp_in.
- en=0: an=all 1, seg=1111111, dp=1 on the next edge; prescaler and digit_idx are held, no frame_done.
  - On en=1 the scan resumes from the held state.
- Duty cycle per digit is exactly REFRESH_DIV cycles. There is no ghosting guard; the anode and segment changes are on the same edge.

Test Plan:
- NUM_DIGITS=4, REFRESH_DIV=4: release reset, en=1 -> an sequence 1110,1101,1011,0111 repeating, each held 4 cycles; frame_done pulses every 16 cycles; outputs all-high during reset.
- load value=16'h9AbF, dp_in=4'b0100 mid-frame -> display unchanged until the wrap. Then:
  - digit0 seg=0111000, digit1 seg=1100000, digit2 seg=0001000 with dp=0, digit3 seg=0000100.
- LZ_BLANK=1, value=16'h0030 -> digits 3 and 2 seg=1111111, digit1=0000110, digit0=0000001.
  - value=16'h0000 -> only digit0 lit, showing 0000001.
- load 16'h1111 then 16'h2222 in consecutive cycles before a wrap -> after the wrap all digits show 2 (0010010).
  - load asserted on the wrap edge -> the new data appears one frame later.
- en=0 for 10 cycles mid-digit -> an=1111, seg=1111111, digit_idx frozen; en=1 -> the same digit resumes with its remaining prescaler count.
- rst_n=0 for 1 cycle mid-frame with a pending load -> outputs dark, digit_idx=0, display regs=0 (digit0 shows 0000001 once en=1), pending discarded.
